rll_key_loader: RTL and testbench

- Upstream stage for the 32-input / 32-key random-logic-locked benchmark netlists.
- Receives the secret key as a serial bitstream with an even-parity trailer, verifies it, and drives it in parallel onto the locked netlist's key inputs.
- Also registers the functional input vector. That vector is forced to zero until a verified key is committed, so the locked core is never exercised with a partial or corrupt key.

---
 rtl/rll_key_loader.sv | 128 ++++++++++++
 tb/tb_rll_key_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_loader.sv
// Serial key loader for random-logic-locked netlists: shifts in an MSB-first key
// with an even-parity trailer, commits it in parallel and gates the functional vector.
module rll_key_loader #(
  parameter int KEY_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  key_sdi,
  input  logic                  key_sdi_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_ready,
  output logic                  load_busy,
  output logic                  load_err,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int BIT_CNT_W  = $clog2(KEY_WIDTH);
  localparam int IDLE_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(KEY_WIDTH - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(TIMEOUT - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX  = IDLE_CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t                  state, state_next;
  logic [KEY_WIDTH-1:0]    shreg;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [IDLE_CNT_W-1:0]   idle_cnt;
  logic                    parity_acc;

  logic do_init, do_shift, do_commit, do_fail, idle_clr, idle_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    do_init    = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    do_fail    = 1'b0;
    idle_clr   = 1'b0;
    idle_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          do_init    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT, PARITY: begin
        // Restart wins over a simultaneous data or parity bit.
        if (load_start) begin
          do_init    = 1'b1;
          state_next = SHIFT;
        end else if (key_sdi_valid) begin
          idle_clr = 1'b1;
          if (state == SHIFT) begin
            do_shift = 1'b1;
            if (bit_cnt == LAST_BIT) state_next = PARITY;
          end else begin
            if (parity_acc ^ key_sdi) do_fail   = 1'b1;
            else                      do_commit = 1'b1;
            state_next = IDLE;
          end
        end else begin
          idle_inc = 1'b1;
          // The edge that would bring idle_cnt to TIMEOUT is the timeout edge.
          if (idle_cnt == IDLE_LAST) begin
            do_fail    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      parity_acc <= 1'b0;
      key_out    <= '0;
      key_ready  <= 1'b0;
      load_err   <= 1'b0;
    end else if (do_init) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      parity_acc <= 1'b0;
      key_out    <= '0;
      key_ready  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      if (do_shift) begin
        shreg      <= {shreg[KEY_WIDTH-2:0], key_sdi};
        parity_acc <= parity_acc ^ key_sdi;
        bit_cnt    <= bit_cnt + 1'b1;
      end
      if (idle_clr) idle_cnt <= '0;
      else if (idle_inc && idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      if (do_commit) begin
        key_out   <= shreg;
        key_ready <= 1'b1;
      end
      if (do_fail) load_err <= 1'b1;
    end
  end

  // The locked core only sees live inputs while a verified key is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= key_ready ? din : '0;
  end

  assign load_busy = (state != IDLE);

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: scenario tasks with a queue of expected
// load outcomes pushed at stimulus time and popped when the load completes.
module tb_rll_key_loader;

  localparam int KW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          key_sdi;
  logic          key_sdi_valid;
  logic [DW-1:0] din;
  logic [KW-1:0] key_out;
  logic          key_ready;
  logic          load_busy;
  logic          load_err;
  logic [DW-1:0] dout;

  typedef struct {
    logic [KW-1:0] key;
    logic          ready;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  rll_key_loader #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .key_sdi       (key_sdi),
    .key_sdi_valid (key_sdi_valid),
    .din           (din),
    .key_out       (key_out),
    .key_ready     (key_ready),
    .load_busy     (load_busy),
    .load_err      (load_err),
    .dout          (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    key_sdi_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input logic with_valid);
    load_start    = 1'b1;
    key_sdi_valid = with_valid;
    key_sdi       = 1'b1;
    tick();
    load_start    = 1'b0;
    key_sdi_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_sdi       = b;
    key_sdi_valid = 1'b1;
    tick();
    key_sdi_valid = 1'b0;
  endtask

  // Sends the top n bits of key MSB first, without a parity trailer.
  task automatic send_partial(input logic [KW-1:0] key, input int n);
    for (int i = KW - 1; i >= KW - n; i--) send_bit(key[i]);
  endtask

  // Full key plus parity, each bit preceded by 'gap' idle cycles; records the expected outcome.
  task automatic send_key(input logic [KW-1:0] key, input logic par, input int gap);
    exp_t e;
    e.ready = ((^key) ^ par) == 1'b0;
    e.err   = !e.ready;
    e.key   = e.ready ? key : '0;
    exp_q.push_back(e);
    for (int i = KW - 1; i >= 0; i--) begin
      idle(gap);
      send_bit(key[i]);
    end
    idle(gap);
    send_bit(par);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    load_start = 1'b0; key_sdi = 1'b0; key_sdi_valid = 1'b0; din = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({key_out, key_ready, load_busy, load_err, dout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got key=%h rdy=%b busy=%b err=%b dout=%h, want all zero",
               key_out, key_ready, load_busy, load_err, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_load();
    exp_t e;
    din = 32'h1234_5678;
    pulse_start(1'b0);
    tests_run++;
    if (load_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL good_busy: got %b want 1", load_busy);
    end
    send_key(32'hA5A5_0F0F, 1'b0, 0);
    e = exp_q.pop_front();
    tests_run++;
    if (key_out !== e.key || key_ready !== e.ready || load_err !== e.err || load_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL good_commit: got key=%h rdy=%b err=%b busy=%b want key=%h rdy=%b err=%b busy=0",
               key_out, key_ready, load_err, load_busy, e.key, e.ready, e.err);
    end
    tests_run++;
    if (dout !== '0) begin
      tests_failed++;
      $display("FAIL good_dout_lat: got %h want 0 on commit edge", dout);
    end
    tick();
    tests_run++;
    if (dout !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL good_dout: got %h want 12345678", dout);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    din = 32'hCAFE_F00D;
    pulse_start(1'b0);
    tests_run++;
    if (key_ready !== 1'b0 || key_out !== '0) begin
      tests_failed++;
      $display("FAIL restart_drop: got rdy=%b key=%h want rdy=0 key=0", key_ready, key_out);
    end
    send_partial(32'hFFC0_0000, 10);
    tests_run++;
    if (dout !== '0) begin
      tests_failed++;
      $display("FAIL restart_dout: got %h want 0", dout);
    end
    // Second restart coincides with a valid bit, which must be discarded.
    pulse_start(1'b1);
    send_key(32'h0000_FFFF, 1'b0, 0);
    e = exp_q.pop_front();
    tests_run++;
    if (key_out !== e.key || key_ready !== e.ready || load_err !== e.err) begin
      tests_failed++;
      $display("FAIL restart_commit: got key=%h rdy=%b err=%b want key=%h rdy=%b err=%b",
               key_out, key_ready, load_err, e.key, e.ready, e.err);
    end
    tick();
    tests_run++;
    if (dout !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL restart_dout_live: got %h want cafef00d", dout);
    end
  endtask

  task automatic test_bad_parity();
    exp_t e;
    pulse_start(1'b0);
    send_key(32'h0000_0001, 1'b0, 0);
    e = exp_q.pop_front();
    tests_run++;
    if (key_out !== e.key || key_ready !== e.ready || load_err !== e.err || load_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_parity: got key=%h rdy=%b err=%b busy=%b want key=%h rdy=%b err=%b busy=0",
               key_out, key_ready, load_err, load_busy, e.key, e.ready, e.err);
    end
    for (int i = 0; i < 4; i++) begin
      din = $urandom() | 32'h1;
      tick();
      tests_run++;
      if (dout !== '0 || load_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL bad_parity_gate: cycle %0d got dout=%h err=%b want dout=0 err=1", i, dout, load_err);
      end
    end
  endtask

  task automatic test_timeout();
    pulse_start(1'b0);
    send_partial(32'hFFFF_FFFF, 5);
    idle(TO - 1);
    tests_run++;
    if (load_err !== 1'b0 || load_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: got err=%b busy=%b want err=0 busy=1", load_err, load_busy);
    end
    idle(1);
    tests_run++;
    if (load_err !== 1'b1 || load_busy !== 1'b0 || key_ready !== 1'b0 || key_out !== '0) begin
      tests_failed++;
      $display("FAIL timeout_hit: got err=%b busy=%b rdy=%b key=%h want err=1 busy=0 rdy=0 key=0",
               load_err, load_busy, key_ready, key_out);
    end
  endtask

  task automatic test_gap_boundary();
    exp_t           e;
    logic [KW-1:0]  key;
    key = 32'h3C96_5AA1;
    pulse_start(1'b0);
    send_key(key, ^key, TO - 1);
    e = exp_q.pop_front();
    tests_run++;
    if (key_out !== e.key || key_ready !== e.ready || load_err !== e.err) begin
      tests_failed++;
      $display("FAIL gap_boundary: got key=%h rdy=%b err=%b want key=%h rdy=%b err=%b",
               key_out, key_ready, load_err, e.key, e.ready, e.err);
    end
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0);
    send_partial(32'h9ABC_DEF0, 20);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({key_out, key_ready, load_busy, load_err, dout} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got key=%h rdy=%b busy=%b err=%b dout=%h want all zero",
               key_out, key_ready, load_busy, load_err, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) send_bit(i[0]);
    tests_run++;
    if (load_busy !== 1'b0 || key_ready !== 1'b0 || key_out !== '0 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignore: got busy=%b rdy=%b key=%h err=%b want all zero",
               load_busy, key_ready, key_out, load_err);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_restart();
    test_bad_parity();
    test_timeout();
    test_gap_boundary();
    test_async_reset();
    apply_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
